// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start, ready, valid, ack, bout, zero, ovf;
    logic [WIDTH-1:0] a, b, d;
    modport master (output start, a, b, ack, input ready, valid, d, bout, zero, ovf);
    modport slave  (input start, a, b, ack, output ready, valid, d, bout, zero, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with one borrow flop, start/ready in, valid/ack out
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sd_q, sd_d, d_q, d_d, sd_n;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, am_q, am_d, bm_q, bm_d;
    logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic             di, br_n;
    assign di   = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_n = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign sd_n = {di, sd_q[WIDTH-1:1]};
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        am_d    = am_q;
        bm_d    = bm_q;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                sa_d    = bus.a;
                sb_d    = bus.b;
                am_d    = bus.a[WIDTH-1];
                bm_d    = bus.b[WIDTH-1];
                br_d    = 1'b0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sd_d  = sd_n;
                br_d  = br_n;
                cnt_d = cnt_q + CW'(1);
                // the final bit computed this edge is the sign of the difference
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    d_d     = sd_n;
                    bout_d  = br_n;
                    zero_d  = sd_n == '0;
                    ovf_d   = (am_q != bm_q) && (di != am_q);
                end
            end
            DONE: state_d = bus.ack ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end
    assign bus.ready = state_q == IDLE;
    assign bus.valid = state_q == DONE;
    assign bus.d     = d_q;
    assign bus.bout  = bout_q;
    assign bus.zero  = zero_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing d = a - b, one bit per clock, LSB first.
- Uses a single borrow flip-flop and a WIDTH-deep shift datapath instead of a ripple chain.
- Serves area-constrained or multi-cycle ALU paths: compare, branch-condition evaluation and test-harness arithmetic.
- Operands are accepted through a start/ready handshake. The result is returned through a valid/ack handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..64).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  minuend; latched when start is accepted.
- b  input  WIDTH  subtrahend; latched when start is accepted.
- ready  output  1  block is idle and can accept start.
- valid  output  1  result is available on d/bout/zero/ovf.
- ack  input  1  consumer takes the result; meaningful only while valid=1.
- d  output  WIDTH  difference a - b, modulo 2^WIDTH.
- bout  output  1  final borrow; 1 iff a < b unsigned.
- zero  output  1  1 iff d == 0.
- ovf  output  1  signed overflow of a - b.

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high.
- Reset values: state=IDLE, ready=1, valid=0, d=0, bout=0, zero=0, ovf=0. Internal shift registers, borrow flip-flop and bit counter are all cleared.
- State machine states: IDLE, RUN, DONE.
- Output decode: ready=1 only in IDLE. valid=1 only in DONE. Both are decoded from registered state, so they are glitch-free.
- IDLE:
  - start=1 at a rising edge latches a into shift register SA and b into SB.
  - The same edge clears borrow and the counter, and moves to RUN.
  - start=0 keeps the block in IDLE.
- RUN, one bit per edge, i = counter:
  - di = SA[0] ^ SB[0] ^ br
  - br_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & br)
  - SA and SB shift right by 1. di shifts into the MSB of shift register SD. The counter increments.
  - On the edge where counter == WIDTH-1, the machine moves to DONE and loads the result registers from the final values.
  - Result register loads: d = completed SD; bout = br_next; zero = (completed SD == 0); ovf = (a_msb != b_msb) && (d_msb != a_msb). a_msb and b_msb are captured at start.
- Latency: with start accepted in cycle 0, RUN occupies cycles 1..WIDTH and valid=1 first in cycle WIDTH+1. Initiation interval is at least WIDTH+2 cycles.
- DONE:
  - valid is held high, and d/bout/zero/ovf are held stable, until ack=1 at an edge. That edge moves the machine to IDLE.
  - ready=1 in the following cycle. There is no timeout.
- Result registers: d/bout/zero/ovf change only on DONE entry or reset. They keep the last result through IDLE and RUN, but are defined only while valid=1.
- Ignored inputs:
  - start while in RUN or DONE is ignored and not queued.
  - ack outside DONE is ignored.
  - start and ack both high in DONE: ack is honoured, start is ignored (ready=0 that cycle).
  - a and b changes after acceptance have no effect.
- Reset mid-operation (RUN or DONE): the operation is aborted and all outputs return to reset values on that edge. No valid pulse is produced for the aborted operation.
- Wrap-around: arithmetic is modulo 2^WIDTH with no saturation. Unsigned underflow is reported only through bout. Signed overflow is reported only through ovf.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, start in cycle 0 -> ready=0 in cycles 1..9; valid=1 in cycle 9 with d=8'h02, bout=0, zero=0, ovf=0; ack -> ready=1 next cycle.
- a=8'h03, b=8'h05 -> d=8'hFE, bout=1, zero=0, ovf=0. a=8'h80, b=8'h01 -> d=8'h7F, bout=0, ovf=1. a=8'h7F, b=8'hFF -> d=8'h80, bout=1, ovf=1.
- a=8'h5A, b=8'h5A -> d=8'h00, zero=1, bout=0, ovf=0. Hold ack=0 for 5 cycles -> valid and outputs stay stable. Start pulses during RUN and DONE -> ignored, no second result.
- Reset asserted in cycle 4 of RUN -> next cycle ready=1, valid=0, d=0, all flags 0. A new start with a=8'h10, b=8'h01 -> d=8'h0F.
- Back-to-back: ack and start in consecutive cycles with 8'hFF-8'hFF, then 8'h00-8'h01 -> d=8'h00/zero=1, then d=8'hFF/bout=1. Also run a random sweep of 1000 pairs checked against a - b.
- WIDTH=4 instance: a=4'h8, b=4'h1 -> d=4'h7, ovf=1, valid in cycle 5. Exhaustive 256-pair sweep matches reference arithmetic.
